// File: rtl/cmd_frame_assembler.sv
// Frames UART RX bytes into 48-bit command packets for cmd_fifo, validating
// checksum and opcode, and abandoning frames that stall longer than TIMEOUT_CYCLES.
module cmd_frame_assembler #(
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  SOF_BYTE       = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [47:0] fifo_wr_data,
  output logic        busy,
  output logic        err_checksum,
  output logic        err_opcode,
  output logic        err_overflow,
  output logic        err_timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPC,
    S_ADR,
    S_DAT,
    S_CHK
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_idx;
  logic              r_busy;
  logic              r_wr_en;
  logic [47:0]       r_wr_data;
  logic              r_err_checksum;
  logic              r_err_opcode;
  logic              r_err_overflow;
  logic              r_err_timeout;

  logic [7:0]        r_opcode;
  logic [7:0]        r_addr;
  logic [31:0]       r_data;
  logic [7:0]        r_csum;

  logic              w_opc_ok;
  logic              w_csum_ok;

  assign w_opc_ok  = (r_opcode == 8'h01) || (r_opcode == 8'h02);
  assign w_csum_ok = (rx_data == r_csum);

  // Control FSM: an accepted byte always takes precedence over timeout expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_idx          <= '0;
      r_busy         <= 1'b0;
      r_wr_en        <= 1'b0;
      r_wr_data      <= '0;
      r_err_checksum <= 1'b0;
      r_err_opcode   <= 1'b0;
      r_err_overflow <= 1'b0;
      r_err_timeout  <= 1'b0;
    end else begin
      r_wr_en        <= 1'b0;
      r_err_checksum <= 1'b0;
      r_err_opcode   <= 1'b0;
      r_err_overflow <= 1'b0;
      r_err_timeout  <= 1'b0;
      if (r_state == S_IDLE) begin
        r_cnt <= '0;
        if (rx_valid && (rx_data == SOF_BYTE)) begin
          r_state <= S_OPC;
          r_busy  <= 1'b1;
        end
      end else if (rx_valid) begin
        r_cnt <= '0;
        case (r_state)
          S_OPC: r_state <= S_ADR;
          S_ADR: begin
            r_state <= S_DAT;
            r_idx   <= 2'd0;
          end
          S_DAT: begin
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) r_state <= S_CHK;
          end
          S_CHK: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            if (!w_csum_ok)     r_err_checksum <= 1'b1;
            else if (!w_opc_ok) r_err_opcode   <= 1'b1;
            else if (fifo_full) r_err_overflow <= 1'b1;
            else begin
              r_wr_en   <= 1'b1;
              r_wr_data <= {r_opcode, r_addr, r_data};
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end else if (r_cnt == CNT_LAST) begin
        r_state       <= S_IDLE;
        r_busy        <= 1'b0;
        r_cnt         <= '0;
        r_err_timeout <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Payload capture and running checksum; only read once a full frame is in.
  always_ff @(posedge clk) begin
    if (rx_valid) begin
      case (r_state)
        S_OPC: begin
          r_opcode <= rx_data;
          r_csum   <= rx_data;
        end
        S_ADR: begin
          r_addr <= rx_data;
          r_csum <= r_csum ^ rx_data;
        end
        S_DAT: begin
          r_data <= {r_data[23:0], rx_data};
          r_csum <= r_csum ^ rx_data;
        end
        default: ;
      endcase
    end
  end

  assign fifo_wr_en   = r_wr_en;
  assign fifo_wr_data = r_wr_data;
  assign busy         = r_busy;
  assign err_checksum = r_err_checksum;
  assign err_opcode   = r_err_opcode;
  assign err_overflow = r_err_overflow;
  assign err_timeout  = r_err_timeout;

endmodule

// File: tb/tb_cmd_frame_assembler.sv
// Scoreboard bench for cmd_frame_assembler: stimulus queues expected pushes and
// error pulses with their cycle; a negedge monitor pops and compares.
module tb_cmd_frame_assembler;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [47:0] fifo_wr_data;
  logic        busy;
  logic        err_checksum;
  logic        err_opcode;
  logic        err_overflow;
  logic        err_timeout;

  cmd_frame_assembler #(.TIMEOUT_CYCLES(TO), .SOF_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .busy(busy), .err_checksum(err_checksum), .err_opcode(err_opcode),
    .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event mask bits: {wr_en, checksum, opcode, overflow, timeout}
  localparam logic [4:0] M_PUSH = 5'b10000;
  localparam logic [4:0] M_CS   = 5'b01000;
  localparam logic [4:0] M_OP   = 5'b00100;
  localparam logic [4:0] M_OV   = 5'b00010;
  localparam logic [4:0] M_TO   = 5'b00001;

  typedef struct {
    logic [4:0]  mask;
    logic [47:0] data;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [4:0] m;
    ev_t e;
    m = {fifo_wr_en, err_checksum, err_opcode, err_overflow, err_timeout};
    if (m != 5'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {59'b0, m}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", {59'b0, m}, {59'b0, e.mask});
        check("event_cycle", cyc, e.cyc);
        if (e.mask[4]) check("push_data", {16'b0, fifo_wr_data}, {16'b0, e.data});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic expect_ev(input logic [4:0] m, input logic [47:0] d, input int c);
    ev_t e;
    e.mask = m;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Frame bytes packed MSB-first: SOF in [63:56], CSUM in [7:0].
  task automatic send_frame(input logic [63:0] f, input logic [4:0] m);
    for (int i = 7; i >= 0; i--) send_byte(f[i*8 +: 8]);
    expect_ev(m, f[55:8], cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] F_WRITE = 64'hA5_01_10_DEADBEEF_33;
  localparam logic [63:0] F_READ  = 64'hA5_02_20_00000000_22;
  localparam logic [63:0] F_BADCS = 64'hA5_01_10_DEADBEEF_34;
  localparam logic [63:0] F_BADOP = 64'hA5_07_00_00000000_07;

  initial begin
    int c0;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; fifo_full = 1'b0;
    idle(3);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_wr_data", fifo_wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_errs", {err_checksum, err_opcode, err_overflow, err_timeout}, 0);
    rst = 1'b0;
    idle(2);

    // Single valid WRITE
    send_frame(F_WRITE, M_PUSH);
    idle(2);
    check("busy_after_write", busy, 0);

    // READ immediately followed by WRITE
    send_frame(F_READ, M_PUSH);
    send_frame(F_WRITE, M_PUSH);
    idle(3);

    // Checksum then opcode errors; last pushed data must be held
    send_frame(F_BADCS, M_CS);
    idle(2);
    check("wr_data_hold", fifo_wr_data, 48'h01_10_DEADBEEF);
    send_frame(F_BADOP, M_OP);
    idle(2);

    // Overflow, then resend with room
    fifo_full = 1'b1;
    send_frame(F_WRITE, M_OV);
    idle(2);
    fifo_full = 1'b0;
    send_frame(F_WRITE, M_PUSH);
    idle(2);

    // Timeout after SOF + opcode
    send_byte(8'hA5);
    send_byte(8'h01);
    c0 = cyc;
    check("busy_mid_frame", busy, 1);
    expect_ev(M_TO, 48'h0, c0 + TO);
    idle(TO + 3);
    check("busy_after_timeout", busy, 0);
    send_frame(F_WRITE, M_PUSH);
    idle(2);

    // Byte landing exactly on the expiry edge is accepted
    send_byte(8'hA5);
    send_byte(8'h01);
    idle(TO - 1);
    send_byte(8'h10);
    check("busy_after_expiry_byte", busy, 1);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    send_byte(8'h33);
    expect_ev(M_PUSH, 48'h01_10_DEADBEEF, cyc);
    idle(2);

    // Reset mid-frame, then trailing bytes of the dead frame must be ignored
    send_frame(F_READ, M_PUSH);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'hDE);
    rst = 1'b1;
    #2;
    check("midrst_busy", busy, 0);
    check("midrst_wr_data", fifo_wr_data, 0);
    check("midrst_wr_en", fifo_wr_en, 0);
    idle(1);
    rst = 1'b0;
    send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h33);
    idle(2);
    check("busy_after_midrst", busy, 0);

    // Leading garbage before a good frame
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    send_frame(F_WRITE, M_PUSH);
    idle(5);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_frame_assembler.md
# cmd_frame_assembler

Converts the UART receiver's byte stream into `cmd_packet_t` commands and pushes them into `cmd_fifo`. It sits between the UART RX byte interface and the command FIFO. It frames, validates and times out host commands, so the FIFO only ever holds complete, well-formed packets.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 100000: maximum idle clocks allowed between bytes inside a frame (1 ms at 100 MHz).
- `SOF_BYTE`, 8'hA5: start-of-frame marker.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is a new byte.
- `rx_data`  in  8  received byte.
- `fifo_full`  in  1  `full` from `cmd_fifo`.
- `fifo_wr_en`  out  1  one-cycle write strobe to `cmd_fifo`.
- `fifo_wr_data`  out  48  `cmd_packet_t` = {opcode[47:40], addr[39:32], data[31:0]}.
- `busy`  out  1  high while a frame is partially received.
- `err_checksum`  out  1  one-cycle pulse on checksum mismatch.
- `err_opcode`  out  1  one-cycle pulse on unsupported opcode.
- `err_overflow`  out  1  one-cycle pulse when a valid frame is dropped because the FIFO is full.
- `err_timeout`  out  1  one-cycle pulse when a frame is abandoned on timeout.

## Operation
- Frame format is 8 bytes: SOF, OPCODE, ADDR, D3, D2, D1, D0 (data MSB first), CSUM.
- CSUM is the XOR of OPCODE, ADDR and D3..D0.
- Supported opcodes: 8'h01 WRITE, 8'h02 READ. READ frames still carry 4 data bytes, which are ignored downstream.
- FSM states and transitions:
  - IDLE: on `rx_valid` with `rx_data == SOF_BYTE`, go to OPC. All other bytes are silently discarded.
  - OPC: on byte, latch opcode, initialise the running checksum to the byte, go to ADR.
  - ADR: on byte, latch addr, XOR it into the checksum, go to DAT.
  - DAT: 2-bit byte index 0..3; each byte shifts into data[31:0] from the LSB side and XORs into the checksum. After index 3, go to CHK.
  - CHK: on byte, evaluate the frame and go to IDLE.
- CHK evaluation uses a strict priority:
  1. checksum mismatch → `err_checksum`;
  2. else opcode not in {01, 02} → `err_opcode`;
  3. else `fifo_full == 1` → `err_overflow`;
  4. else push the packet.
- Exactly one outcome occurs per completed frame.
- An SOF value seen mid-frame is treated as ordinary payload; there is no resync.
- Timeout counter: width `$clog2(TIMEOUT_CYCLES)`.
  - Cleared in IDLE and on every accepted byte; increments each clock in states other than IDLE.
  - When it reaches `TIMEOUT_CYCLES-1` without a byte, pulse `err_timeout` and go to IDLE.
  - A byte arriving on that same edge wins: it is accepted and no timeout occurs.
- `busy` = (state != IDLE).

## Timing
- Reset values: state IDLE, counters 0, `fifo_wr_en` 0, `fifo_wr_data` 0, `busy` 0, all `err_*` 0.
- Reset mid-frame discards the partial frame with no error pulse and no write.
- All outputs are registered.
- `fifo_wr_en` and the `err_*` pulses assert in the cycle after the edge that accepts the CSUM byte, for exactly one cycle.
- `fifo_wr_data` is valid while `fifo_wr_en` is high and holds its value until the next push.
- `fifo_full` is sampled at the CSUM-accept edge. Frames are at least 8 bytes apart, so writes are never back-to-back and the sampled `full` always reflects every prior push.
- Throughput: bytes are accepted on every cycle with `rx_valid`, including consecutive cycles. There is no backpressure to the UART.
- The SOF of the next frame is accepted in the same cycle that `fifo_wr_en` is high.

## Test plan
- **Valid WRITE.** Bytes A5 01 10 DE AD BE EF 33 → one `fifo_wr_en` pulse one cycle after byte 33, with `fifo_wr_data` = 48'h01_10_DEADBEEF. No error pulses; `busy` is low afterwards.
- **Valid READ, back-to-back.** A5 02 20 00 00 00 00 22 immediately followed by the WRITE frame above → two pushes in order, 8 cycles apart; data 48'h02_20_00000000, then 48'h01_10_DEADBEEF.
- **Checksum and opcode errors.**
  - WRITE frame with CSUM 34 → `err_checksum` only; no push.
  - A5 07 00 00 00 00 00 07 → `err_opcode` only; no push.
- **Overflow.** `fifo_full` = 1, valid WRITE frame → `err_overflow`, no `fifo_wr_en`. Deassert `fifo_full` and resend → push occurs.
- **Timeout.**
  - A5 01 then silence → `err_timeout` exactly `TIMEOUT_CYCLES` clocks after byte 01, and `busy` falls.
  - A following full frame pushes correctly.
  - A byte arriving exactly on the expiry edge is accepted with no timeout.
- **Reset and noise.**
  - Assert `rst` after byte 4 of a frame → all outputs 0, no pulses.
  - Leading garbage bytes 00 FF 5A before A5 … → ignored; the frame pushes normally.
